// File: rtl/pwm_bank.sv
// Multi-channel PWM peripheral: one shared prescaled timebase (edge/center aligned)
// drives CHANNELS outputs with double-buffered cutoffs behind a register port.
module pwm_bank #(
    parameter int CHANNELS      = 4,
    parameter int DATA_BITS     = 8,
    parameter int ADDR_BITS     = 5,
    parameter int PRESCALE_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic [CHANNELS-1:0]  pwm_out,
    output logic                 period_tick
);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
    typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} mode_t;

    localparam logic [ADDR_BITS-1:0] A_ENABLE   = ADDR_BITS'(CHANNELS);
    localparam logic [ADDR_BITS-1:0] A_PRESCALE = ADDR_BITS'(CHANNELS + 1);
    localparam logic [ADDR_BITS-1:0] A_MODE     = ADDR_BITS'(CHANNELS + 2);
    localparam logic [ADDR_BITS-1:0] A_STATUS   = ADDR_BITS'(CHANNELS + 3);
    localparam logic [DATA_BITS-1:0] CNT_MAX    = '1;
    localparam logic [DATA_BITS-1:0] CNT_ONE    = DATA_BITS'(1);

    logic [DATA_BITS-1:0]     r_shadow [CHANNELS];
    logic [DATA_BITS-1:0]     r_active [CHANNELS];
    logic [CHANNELS-1:0]      r_enable;
    logic [PRESCALE_BITS-1:0] r_prescale;
    logic [PRESCALE_BITS-1:0] r_presc_cnt;
    mode_t                    r_mode;
    logic                     r_status;
    logic [DATA_BITS-1:0]     r_cnt;
    dir_t                     r_dir;
    logic [CHANNELS-1:0]      r_pwm;
    logic                     r_period_tick;
    logic [DATA_BITS-1:0]     r_rd_data;

    logic                     w_tick;
    logic                     w_boundary;
    logic                     w_mode_wr;
    logic                     w_stat_clr;
    logic [DATA_BITS-1:0]     w_cnt_next;
    dir_t                     w_dir_next;
    logic [CHANNELS-1:0]      w_pwm;
    logic [DATA_BITS-1:0]     w_rd_val;

    assign w_tick     = (r_presc_cnt == r_prescale);
    assign w_mode_wr  = wr_en && (wr_addr == A_MODE);
    assign w_stat_clr = wr_en && (wr_addr == A_STATUS) && wr_data[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_dir <= DIR_UP;
        end else begin
            r_cnt <= w_cnt_next;
            r_dir <= w_dir_next;
        end
    end

    // Center mode walks 0..MAX..1; the flip back to up is taken on the 1->0 step,
    // so that tick is also the period boundary.
    always_comb begin
        w_cnt_next = r_cnt;
        w_dir_next = r_dir;
        w_boundary = 1'b0;
        if (w_tick) begin
            if (r_mode == MODE_EDGE) begin
                w_cnt_next = r_cnt + 1'b1;
                w_boundary = (r_cnt == CNT_MAX);
            end else if (r_dir == DIR_UP) begin
                if (r_cnt == CNT_MAX) begin
                    w_cnt_next = r_cnt - 1'b1;
                    w_dir_next = DIR_DOWN;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end else begin
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt == CNT_ONE) begin
                    w_dir_next = DIR_UP;
                    w_boundary = 1'b1;
                end
            end
        end
        if (w_mode_wr) begin
            w_cnt_next = '0;
            w_dir_next = DIR_UP;
        end
    end

    always_comb begin
        w_pwm = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_pwm[i] = r_enable[i] && (r_cnt < r_active[i]);
        end
    end

    always_comb begin
        w_rd_val = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (rd_addr == ADDR_BITS'(i)) w_rd_val = r_shadow[i];
        end
        if (rd_addr == A_ENABLE)   w_rd_val = DATA_BITS'(r_enable);
        if (rd_addr == A_PRESCALE) w_rd_val = DATA_BITS'(r_prescale);
        if (rd_addr == A_MODE)     w_rd_val = {{(DATA_BITS-1){1'b0}}, r_mode == MODE_CENTER};
        if (rd_addr == A_STATUS)   w_rd_val = {{(DATA_BITS-1){1'b0}}, r_status};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enable      <= '0;
            r_prescale    <= '0;
            r_presc_cnt   <= '0;
            r_mode        <= MODE_EDGE;
            r_status      <= 1'b0;
            r_pwm         <= '0;
            r_period_tick <= 1'b0;
            r_rd_data     <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_pwm         <= w_pwm;
            r_period_tick <= w_boundary;
            r_status      <= w_boundary | (r_status & ~w_stat_clr);
            if (rd_en) r_rd_data <= w_rd_val;

            if (w_mode_wr || w_tick) r_presc_cnt <= '0;
            else                     r_presc_cnt <= r_presc_cnt + 1'b1;

            // Active reloads read the pre-write shadow, so a same-cycle write waits a period.
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (w_mode_wr || w_boundary || !r_enable[i]) r_active[i] <= r_shadow[i];
                if (wr_en && (wr_addr == ADDR_BITS'(i)))     r_shadow[i] <= wr_data;
            end

            if (wr_en && (wr_addr == A_ENABLE))   r_enable   <= CHANNELS'(wr_data);
            if (wr_en && (wr_addr == A_PRESCALE)) r_prescale <= PRESCALE_BITS'(wr_data);
            if (w_mode_wr)                        r_mode     <= mode_t'(wr_data[0]);
        end
    end

    assign pwm_out     = r_pwm;
    assign period_tick = r_period_tick;
    assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: directed period measurements plus random traffic, all
// checked cycle-by-cycle against a position-in-period reference model.
module tb_pwm_bank;

    localparam int CH   = 4;
    localparam int DB   = 8;
    localparam int AB   = 5;
    localparam int PB   = 8;
    localparam int MAXV = (1 << DB) - 1;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [AB-1:0] wr_addr;
    logic [DB-1:0] wr_data;
    logic          rd_en;
    logic [AB-1:0] rd_addr;
    logic [DB-1:0] rd_data;
    logic [CH-1:0] pwm_out;
    logic          period_tick;

    pwm_bank #(
        .CHANNELS      (CH),
        .DATA_BITS     (DB),
        .ADDR_BITS     (AB),
        .PRESCALE_BITS (PB)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: timebase tracked as a position within the period;
    // the counter value is derived from it arithmetically.
    int m_shadow [CH];
    int m_active [CH];
    int m_en, m_presc, m_mode, m_status, m_pc, m_pos, m_pwm, m_tick, m_rd;

    function automatic int model_read(input int a);
        if (a < CH)     return m_shadow[a];
        if (a == CH)    return m_en;
        if (a == CH+1)  return m_presc;
        if (a == CH+2)  return m_mode;
        if (a == CH+3)  return m_status;
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < CH; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
        m_en = 0; m_presc = 0; m_mode = 0; m_status = 0;
        m_pc = 0; m_pos = 0; m_pwm = 0; m_tick = 0; m_rd = 0;
    endtask

    task automatic model_step();
        int period, cnt, pwm, wa, wd;
        bit tk, bnd;
        period = (m_mode != 0) ? 2*MAXV : MAXV+1;
        cnt    = (m_mode != 0 && m_pos > MAXV) ? 2*MAXV - m_pos : m_pos;
        tk     = (m_pc == m_presc);
        bnd    = tk && (m_pos == period - 1);
        wa     = int'(wr_addr);
        wd     = int'(wr_data);
        pwm = 0;
        for (int i = 0; i < CH; i++)
            if (((m_en >> i) & 1) == 1 && cnt < m_active[i]) pwm |= (1 << i);
        if (rd_en) m_rd = model_read(int'(rd_addr));
        for (int i = 0; i < CH; i++)
            if (bnd || ((m_en >> i) & 1) == 0) m_active[i] = m_shadow[i];
        if (bnd) m_status = 1;
        else if (wr_en && wa == CH+3 && (wd & 1) == 1) m_status = 0;
        if (tk) begin
            m_pc  = 0;
            m_pos = (m_pos + 1) % period;
        end else begin
            m_pc = (m_pc + 1) % (1 << PB);
        end
        if (wr_en) begin
            if (wa < CH) m_shadow[wa] = wd;
            else if (wa == CH)   m_en    = wd & ((1 << CH) - 1);
            else if (wa == CH+1) m_presc = wd & ((1 << PB) - 1);
            else if (wa == CH+2) begin
                m_mode = wd & 1;
                m_pos  = 0;
                m_pc   = 0;
                for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
            end
        end
        m_pwm  = pwm;
        m_tick = bnd ? 1 : 0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_clear();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check_eq("sb_pwm",  int'(pwm_out),     m_pwm);
            check_eq("sb_tick", int'(period_tick), m_tick);
            check_eq("sb_rd",   int'(rd_data),     m_rd);
        end
    end

    int hist [0:1023];

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = AB'(a); wr_data = DB'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input int a, output int v);
        rd_en = 1'b1; rd_addr = AB'(a);
        @(negedge clk);
        rd_en = 1'b0;
        v = int'(rd_data);
    endtask

    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_tick !== 1'b1 && n < limit);
        if (period_tick !== 1'b1) check_eq("tick_timeout", n, -1);
    endtask

    // Samples n cycles after a period_tick; optionally issues one write after sample wr_at.
    task automatic run_period(input int n, input int ch, input int wr_at, input int a,
                              input int d, output int hi, output int ticks, output int other);
        int po;
        hi = 0; ticks = 0; other = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            po      = int'(pwm_out);
            hist[i] = (po >> ch) & 1;
            hi     += hist[i];
            ticks  += int'(period_tick);
            if ((po & ~(1 << ch)) != 0) other++;
            if (i == wr_at) begin
                wr_en = 1'b1; wr_addr = AB'(a); wr_data = DB'(d);
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic read_all_zero();
        int v;
        for (int a = 0; a < CH + 4; a++) begin
            rd(a, v);
            check_eq("rd_after_reset", v, 0);
        end
        rd((1 << AB) - 1, v);
        check_eq("rd_unmapped", v, 0);
    endtask

    initial begin
        int hi, tk, oth, v, n;
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_eq("rst_pwm", int'(pwm_out), 0);
        read_all_zero();

        // Edge mode, cutoff 64 on channel 0
        wr(0, 64);
        wr(CH, 1);
        wait_tick(600, n);
        run_period(256, 0, -1, 0, 0, hi, tk, oth);
        check_eq("edge_hi", hi, 64);
        check_eq("edge_ticks", tk, 1);
        check_eq("edge_other", oth, 0);

        // Double buffering: mid-period write, then a write on the boundary cycle
        run_period(256, 0, 99, 0, 200, hi, tk, oth);
        check_eq("dbuf_cur", hi, 64);
        run_period(256, 0, -1, 0, 0, hi, tk, oth);
        check_eq("dbuf_next", hi, 200);
        run_period(256, 0, 254, 0, 30, hi, tk, oth);
        check_eq("bnd_wr_cur", hi, 200);
        run_period(256, 0, -1, 0, 0, hi, tk, oth);
        check_eq("bnd_wr_next", hi, 200);
        run_period(256, 0, -1, 0, 0, hi, tk, oth);
        check_eq("bnd_wr_later", hi, 30);
        check_eq("bnd_wr_ticks", tk, 1);

        // Asynchronous reset while channel 0 is high
        wait_tick(600, n);
        repeat (10) @(negedge clk);
        check_eq("pre_rst_hi", int'(pwm_out[0]), 1);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_pwm", int'(pwm_out), 0);
        check_eq("async_rst_tick", int'(period_tick), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        read_all_zero();

        // Prescale 3, channel 1 at half duty
        wr(1, 128);
        wr(CH, 2);
        wr(CH+1, 3);
        wait_tick(3000, n);
        run_period(1024, 1, -1, 0, 0, hi, tk, oth);
        check_eq("presc_hi", hi, 512);
        check_eq("presc_ticks", tk, 1);
        check_eq("presc_other", oth, 0);

        // Status flag: set by boundary, W1C, set wins over coincident clear
        wr(CH+1, 0);
        wait_tick(2000, n);
        rd(CH+3, v);
        check_eq("status_set", v, 1);
        wr(CH+3, 1);
        rd(CH+3, v);
        check_eq("status_clr", v, 0);
        wait_tick(600, n);
        run_period(256, 0, 254, CH+3, 1, hi, tk, oth);
        rd(CH+3, v);
        check_eq("status_set_wins", v, 1);
        wr((1 << AB) - 1, 255);
        rd((1 << AB) - 1, v);
        check_eq("unmapped_wr", v, 0);
        rd(CH+1, v);
        check_eq("presc_readback", v, 0);

        // Center mode, cutoff 10
        wr(0, 10);
        wr(CH, 1);
        wr(CH+2, 1);
        wait_tick(2000, n);
        check_eq("ctr_restart", n, 510);
        run_period(510, 0, -1, 0, 0, hi, tk, oth);
        check_eq("ctr_hi", hi, 19);
        check_eq("ctr_ticks", tk, 1);
        check_eq("ctr_h0", hist[0], 1);
        check_eq("ctr_h9", hist[9], 1);
        check_eq("ctr_h10", hist[10], 0);
        check_eq("ctr_h500", hist[500], 0);
        check_eq("ctr_h501", hist[501], 1);
        check_eq("ctr_h509", hist[509], 1);
        rd(CH+2, v);
        check_eq("mode_readback", v, 1);

        // Random register traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int a;
            a = ($urandom_range(0, 15) == 0) ? (1 << AB) - 1 : int'($urandom_range(0, CH + 4));
            wr_en   = ($urandom_range(0, 19) == 0);
            if (a == CH+2 && $urandom_range(0, 3) != 0) wr_en = 1'b0;
            wr_addr = AB'(a);
            wr_data = (a == CH+1) ? DB'($urandom_range(0, 3)) : DB'($urandom);
            rd_en   = $urandom_range(0, 1) == 1;
            rd_addr = AB'($urandom_range(0, (1 << AB) - 1));
            @(negedge clk);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
